// File: rtl/int2float_pkg.sv
// Shared types and helpers for the 11-bit integer to 7-bit float converter path.
package int2float_pkg;

    localparam int unsigned INT_W = 11;
    localparam int unsigned FP_W  = 7;

    typedef logic [INT_W-1:0] operand_t;
    typedef logic [FP_W-1:0]  result_t;

    // Operand bit k drives converter input xk; kept as a function so a
    // future reordering of the converter pins stays in one place.
    function automatic operand_t to_conv_x(input operand_t v);
        operand_t x;
        for (int unsigned k = 0; k < INT_W; k++) begin
            x[k] = v[k];
        end
        return x;
    endfunction

endpackage

// File: rtl/int2float_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible requester searching upward from ptr.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Rotating priority search; the found flag keeps only the first hit.
    always_comb begin
        logic        found;
        int unsigned k;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            k = (int'(ptr) + off) % N;
            if (en && !found && elig[k]) begin
                gnt[k] = 1'b1;
                idx    = IW'(k);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int2float_sched.sv
// Shares one combinational int-to-float converter among NREQ requesters,
// with a one-deep response slot per requester.
module int2float_sched
    import int2float_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*INT_W-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*FP_W-1:0]   rsp_data,
    input  logic [NREQ-1:0]        rsp_ready,
    input  logic                   hold,
    output logic [INT_W-1:0]       conv_x,
    input  logic [FP_W-1:0]        conv_y,
    output logic                   idle,
    output logic [CNTW-1:0]        conv_count
);

    localparam int unsigned IW = $clog2(NREQ);

    logic          fl_vld;
    logic [IW-1:0] fl_id;
    logic [IW-1:0] ptr;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    operand_t        sel_op;

    // A requester is eligible only with nothing outstanding (slot empty, not in flight).
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] & ~rsp_valid[i] & ~(fl_vld && (fl_id == IW'(i)));
        end
    end

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .elig (elig),
        .ptr  (ptr),
        .en   (~hold & ~rst),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign req_ready = gnt;
    assign idle      = ~fl_vld & ~|rsp_valid;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = req_data[i*INT_W +: INT_W];
            end
        end
    end

    // Grant register stage: operand to the converter, in-flight tag, rotating pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_x <= '0;
            fl_vld <= 1'b0;
            fl_id  <= '0;
            ptr    <= '0;
        end else if (|gnt) begin
            conv_x <= to_conv_x(sel_op);
            fl_vld <= 1'b1;
            fl_id  <= gnt_idx;
            ptr    <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
        end else begin
            fl_vld <= 1'b0;
        end
    end

    // Capture stage: converter result into the originating slot, release on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            conv_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (fl_vld && (fl_id == IW'(i))) begin
                    rsp_valid[i]               <= 1'b1;
                    rsp_data[i*FP_W +: FP_W]   <= conv_y;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (fl_vld && (conv_count != '1)) begin
                conv_count <= conv_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_int2float_sched.sv
// Directed bench for int2float_sched with a stand-in converter on conv_x/conv_y.
module tb_int2float_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [43:0] req_data;
    logic [27:0] rsp_data;
    logic        hold;
    logic [10:0] conv_x;
    logic [6:0]  conv_y;
    logic        idle;
    logic [15:0] conv_count;

    logic        rst2;
    logic [1:0]  req_valid2, req_ready2, rsp_valid2, rsp_ready2;
    logic [21:0] req_data2;
    logic [13:0] rsp_data2;
    logic        hold2;
    logic [10:0] conv_x2;
    logic [6:0]  conv_y2;
    logic        idle2;
    logic [3:0]  conv_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared converter: any fixed combinational map works here.
    function automatic logic [6:0] cvt(input logic [10:0] x);
        logic [6:0] hi;
        hi = {x[10:7], 3'b000};
        return x[6:0] ^ hi;
    endfunction

    assign conv_y  = cvt(conv_x);
    assign conv_y2 = cvt(conv_x2);

    int2float_sched #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .hold(hold), .conv_x(conv_x), .conv_y(conv_y),
        .idle(idle), .conv_count(conv_count)
    );

    int2float_sched #(.NREQ(2), .CNTW(4)) dut_sat (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .rsp_ready(rsp_ready2), .hold(hold2), .conv_x(conv_x2), .conv_y(conv_y2),
        .idle(idle2), .conv_count(conv_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int unsigned i, input logic [10:0] v);
        req_data[i*11 +: 11] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        hold      = 1'b0;
        rsp_ready = 4'hf;
        req_valid = 4'hf;
        step();
        #1 check("rst_ready", {28'd0, req_ready}, 32'h0);
        step();
        rst       = 1'b0;
        req_valid = 4'h0;
        #1;
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
        check("rst_conv_x", {21'd0, conv_x}, 32'h0);
        check("rst_count", {16'd0, conv_count}, 32'h0);
        check("rst_idle", {31'd0, idle}, 32'h1);
    endtask

    initial begin
        int gcount[4];
        int mx, mn, g, g1, g2;
        logic [3:0] e;
        logic found;

        rst = 1'b1; rst2 = 1'b1;
        req_valid = '0; req_data = '0; rsp_ready = 4'hf; hold = 1'b0;
        req_valid2 = '0; req_data2 = '0; rsp_ready2 = 2'b11; hold2 = 1'b0;
        for (int unsigned i = 0; i < 4; i++) set_op(i, 11'(11'h100 + i * 11'h137));

        // Single request, 2-cycle latency
        do_reset();
        set_op(0, 11'h000);
        req_valid = 4'b0001;
        #1 check("single_ready", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        #1;
        check("single_conv_x", {21'd0, conv_x}, 32'h0);
        check("single_no_rsp_yet", {28'd0, rsp_valid}, 32'h0);
        check("single_busy", {31'd0, idle}, 32'h0);
        step();
        check("single_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        check("single_rsp_data", {25'd0, rsp_data[6:0]}, {25'd0, cvt(11'h000)});
        check("single_count", {16'd0, conv_count}, 32'd1);
        set_op(3, 11'h5A3);
        req_valid = 4'b1000;
        #1 check("single3_ready", {28'd0, req_ready}, 32'h8);
        step();
        req_valid = 4'b0000;
        #1 check("single3_conv_x", {21'd0, conv_x}, 32'h5A3);
        step();
        check("single3_rsp_valid", {28'd0, rsp_valid}, 32'h8);
        check("single3_rsp_data", {25'd0, rsp_data[27:21]}, {25'd0, cvt(11'h5A3)});
        check("single3_count", {16'd0, conv_count}, 32'd2);
        step();
        check("single3_idle", {31'd0, idle}, 32'h1);

        // Fairness: all valid, all consumers ready
        do_reset();
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        req_valid = 4'hf;
        for (int c = 0; c < 100; c++) begin
            #1;
            e = 4'b0001 << (c % 4);
            check("fair_order", {28'd0, req_ready}, {28'd0, e});
            for (int i = 0; i < 4; i++) if (req_ready[i]) gcount[i]++;
            step();
        end
        req_valid = 4'h0;
        mx = gcount[0]; mn = gcount[0];
        for (int i = 1; i < 4; i++) begin
            if (gcount[i] > mx) mx = gcount[i];
            if (gcount[i] < mn) mn = gcount[i];
        end
        check("fair_spread", {31'd0, (mx - mn) <= 1}, 32'h1);

        // Backpressure on slot 2
        do_reset();
        step();
        step();
        rsp_ready = 4'b1011;
        req_valid = 4'b0110;
        g1 = 0; g2 = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready[1]) g1++;
            if (req_ready[2]) g2++;
            step();
        end
        check("bp_grants2", g2, 32'd1);
        check("bp_grants1", g1, 32'd4);
        check("bp_slot2_held", {31'd0, rsp_valid[2]}, 32'h1);
        check("bp_slot2_data", {25'd0, rsp_data[20:14]}, {25'd0, cvt(11'(11'h100 + 2 * 11'h137))});
        rsp_ready = 4'hf;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            #1;
            if (req_ready[2]) found = 1'b1;
            else step();
        end
        check("bp_release_grant", {31'd0, found}, 32'h1);
        req_valid = 4'h0;

        // Hold mid-stream
        do_reset();
        req_valid = 4'hf;
        #1 check("hold_pre0", {28'd0, req_ready}, 32'h1);
        step();
        check("hold_pre1", {28'd0, req_ready}, 32'h2);
        step();
        hold = 1'b1;
        for (int h = 0; h < 10; h++) begin
            #1 check("hold_ready", {28'd0, req_ready}, 32'h0);
            if (h == 1) begin
                check("hold_inflight_valid", {28'd0, rsp_valid}, 32'h2);
                check("hold_inflight_data", {25'd0, rsp_data[13:7]}, {25'd0, cvt(11'(11'h100 + 11'h137))});
            end
            step();
        end
        check("hold_idle", {31'd0, idle}, 32'h1);
        check("hold_count", {16'd0, conv_count}, 32'd2);
        hold = 1'b0;
        #1 check("hold_resume_ptr", {28'd0, req_ready}, 32'h4);
        req_valid = 4'h0;

        // Reset one cycle after a grant
        do_reset();
        req_valid = 4'b0001;
        #1 check("rmf_grant", {28'd0, req_ready}, 32'h1);
        step();
        rst = 1'b1;
        req_valid = 4'b0000;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rmf_no_rsp", {28'd0, rsp_valid}, 32'h0);
            check("rmf_count", {16'd0, conv_count}, 32'd0);
            step();
        end
        req_valid = 4'hf;
        #1 check("rmf_first_grant", {28'd0, req_ready}, 32'h1);
        req_valid = 4'h0;

        // Saturating counter, CNTW=4
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        #1 check("sat_reset", {28'd0, conv_count2}, 32'd0);
        req_data2  = {11'h2AA, 11'h155};
        req_valid2 = 2'b11;
        g = 0;
        for (int c = 0; c < 60 && g < 20; c++) begin
            #1;
            if (req_ready2 != 2'b00) g++;
            step();
        end
        req_valid2 = 2'b00;
        check("sat_grants", g, 32'd20);
        step(); step(); step();
        check("sat_count", {28'd0, conv_count2}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
